// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds only width-independent definitions.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin.
// Purely combinational.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    import serial_sub_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bo_q, bo_d;
    logic             ov_q, ov_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = res_q;
    assign borrow_out = bo_q;
    assign overflow   = ov_q;

    // Next-state and datapath update for load, shift and hold.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                brw_d = cell_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Hold the counter so it never wraps.
                    cnt_d   = cnt_q;
                    bo_d    = cell_bout;
                    ov_d    = brw_q ^ cell_bout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8 and 4.
// Directed vectors plus an exhaustive 4-bit sweep.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;

    logic       iv8, ir8, vo8, or8, bo8, of8;
    logic [7:0] a8, b8, d8;
    logic       iv4, ir4, vo4, or4, bo4, of4;
    logic [3:0] a4, b4, d4;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8),
        .out_valid(vo8), .out_ready(or8),
        .diff(d8), .borrow_out(bo8), .overflow(of8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(rst),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4),
        .out_valid(vo4), .out_ready(or4),
        .diff(d4), .borrow_out(bo4), .overflow(of4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit bo;
        bit ov;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int errs = 0;
    int checks = 0;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(int w, int a, int b);
        exp_t e;
        int m;
        int sa;
        int sb;
        int r;
        m    = 1 << w;
        e.d  = (a - b + m) % m;
        e.bo = (a < b);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        r    = sa - sb;
        e.ov = (r < -(m / 2)) || (r > m / 2 - 1);
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", n, act, req);
        end
    endtask

    // Result checker: every DONE cycle against the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (vo8) begin
                chk("w8 in_ready in DONE", ir8, 0);
                if (q8.size() == 0) begin
                    chk("w8 unexpected out_valid", 1, 0);
                end else begin
                    chk("w8 diff", d8, q8[0].d);
                    chk("w8 borrow", bo8, q8[0].bo);
                    chk("w8 overflow", of8, q8[0].ov);
                    if (or8) void'(q8.pop_front());
                end
            end
            if (vo4) begin
                chk("w4 in_ready in DONE", ir4, 0);
                if (q4.size() == 0) begin
                    chk("w4 unexpected out_valid", 1, 0);
                end else begin
                    chk("w4 diff", d4, q4[0].d);
                    chk("w4 borrow", bo4, q4[0].bo);
                    chk("w4 overflow", of4, q4[0].ov);
                    if (or4) void'(q4.pop_front());
                end
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int n;
        iv8 = 1'b1;
        a8  = a;
        b8  = b;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir8 && n < 50);
        if (!ir8) chk("w8 in_ready timeout", 0, 1);
        @(posedge clk);
        q8.push_back(model(8, a, b));
        #1;
        iv8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        @(negedge clk);
        while (!vo8 && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        if (!vo8) chk("w8 out_valid timeout", 0, 1);
    endtask

    task automatic release8(input int stall);
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1 or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] xd, input logic xbo,
                       input logic xov);
        int lat;
        send8(a, b);
        wait8(lat);
        chk("w8 latency", lat, 8);
        chk("w8 lit diff", d8, xd);
        chk("w8 lit borrow", bo8, xbo);
        chk("w8 lit overflow", of8, xov);
        release8(0);
    endtask

    task automatic op4(input int a, input int b, input int stall);
        int n;
        int lat;
        iv4 = 1'b1;
        a4  = 4'(a);
        b4  = 4'(b);
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir4 && n < 50);
        if (!ir4) chk("w4 in_ready timeout", 0, 1);
        @(posedge clk);
        q4.push_back(model(4, a, b));
        #1;
        iv4 = 1'b0;
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        lat = 0;
        @(negedge clk);
        while (!vo4 && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        chk("w4 latency", lat, 4);
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1 or4 = 1'b1;
        @(posedge clk);
        #1 or4 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", ir8, 1);
        chk("reset out_valid", vo8, 0);
        chk("reset diff", d8, 0);
        chk("reset borrow", bo8, 0);
        chk("reset overflow", of8, 0);
        chk("reset w4 in_ready", ir4, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        op8(8'hC8, 8'h37, 8'h91, 1'b0, 1'b0);
        op8(8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Backpressure with a stray operand pulse in DONE.
        send8(8'h3C, 8'h11);
        wait8(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            iv8 = (i == 2);
            a8  = 8'hFF;
            b8  = 8'h01;
            @(negedge clk);
            chk("bp out_valid", vo8, 1);
            chk("bp in_ready", ir8, 0);
            chk("bp diff", d8, 8'h2B);
            chk("bp borrow", bo8, 0);
            chk("bp overflow", of8, 0);
        end
        @(posedge clk);
        #1 iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        @(negedge clk);
        chk("bp in_ready after handoff", ir8, 1);
        chk("bp out_valid after handoff", vo8, 0);
        repeat (10) @(negedge clk);
        chk("bp stray operand ignored", vo8, 0);

        // Reset sampled on the 4th shift edge.
        @(posedge clk);
        #1;
        send8(8'hAA, 8'h55);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("mid rst in_ready", ir8, 1);
        chk("mid rst out_valid", vo8, 0);
        chk("mid rst diff", d8, 0);
        chk("mid rst borrow", bo8, 0);
        chk("mid rst overflow", of8, 0);
        @(posedge clk);
        #1;
        op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep with random result stalls.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(a, b, int'($urandom_range(0, 3)));
            end
        end

        repeat (3) @(negedge clk);
        chk("w8 queue drained", q8.size(), 0);
        chk("w4 queue drained", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial, LSB-first N-bit subtractor computing `a - b` one bit per clock through a single one-bit full-subtractor cell and a borrow flip-flop.
- Arithmetic counterpart to the team's combinational ripple adder.
- Used where area matters more than latency: operands in through a valid/ready handshake, result out through a second valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal values are 2 and above.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; takes effect on the rising edge of `clk`.
- `in_valid`  in  1: operands `a`/`b` are valid.
- `in_ready`  out  1: block accepts operands; high only in IDLE.
- `a`  in  WIDTH: minuend, unsigned or two's-complement.
- `b`  in  WIDTH: subtrahend.
- `out_valid`  out  1: result valid; high only in DONE.
- `out_ready`  in  1: consumer accepts result.
- `diff`  out  WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1: unsigned borrow, equal to `a < b`.
- `overflow`  out  1: signed overflow of `a - b`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid`, load the A and B shift registers, clear the borrow flop, clear the bit counter, and go to SHIFT.
- **SHIFT**
  - Each cycle the cell takes `ai = A[0]`, `bi = B[0]` and `bin = borrow flop`.
  - Cell outputs: `d = ai ^ bi ^ bin`; `bout = (~ai & bi) | (~(ai ^ bi) & bin)`.
  - A and B shift right. `d` shifts into the MSB of the result register, which shifts right. The borrow flop takes `bout`. The counter increments.
  - On the cycle with `counter == WIDTH-1` (MSB bit):
    - `borrow_out <= bout`
    - `overflow <= bin ^ bout`
    - state goes to DONE.
- **DONE**
  - `out_valid = 1`.
  - `diff`, `borrow_out` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands must not change the result once accepted, because they are captured at acceptance.
- `in_ready` and `out_valid` are decoded from state (Moore). There is no combinational path from inputs to outputs.
- Counter width is `$clog2(WIDTH)`. The counter never wraps within an operation.

## Timing
- Acceptance edge E0: `in_valid & in_ready` sampled high.
- Shift edges are E1 through E_WIDTH.
- `out_valid` rises in the cycle after E_WIDTH, i.e. WIDTH cycles after acceptance.
- Result handshake edge: `out_valid & out_ready` sampled high; `in_ready` is high in the next cycle.
- Minimum initiation interval is WIDTH+2 cycles. There is no accept in the same cycle as a result handoff.
- `out_ready` low in DONE: hold indefinitely. All outputs stay stable and `in_ready` stays 0.
- Reset, sampled at any edge including mid-SHIFT or in DONE:
  - next state IDLE; the in-flight operation is discarded;
  - `diff = 0`, `borrow_out = 0`, `overflow = 0`, `out_valid = 0`, `in_ready = 1`;
  - shift registers, counter and borrow flop are cleared.
- Reset has priority over every handshake in the same cycle.

## Structure
- Package `serial_sub_pkg` holds:
  - the enum `sub_state_t` {IDLE, SHIFT, DONE};
  - nothing width-dependent.
- Sub-module `full_subtractor` (inputs `a`, `b`, `bin`; outputs `d`, `bout`): purely combinational and instantiated once.
- All registers live in `serial_subtractor`: A, B, result, borrow flop, counter, state, `borrow_out`, `overflow`.

## Test plan
WIDTH=8 unless noted.
- **Basic subtraction:** after reset, `a=0xC8`, `b=0x37`.
  - Result: `diff=0x91`, `borrow_out=0`, `overflow=0`.
  - `out_valid` exactly 8 cycles after acceptance.
- **Unsigned borrow:** `a=0x05`, `b=0x0A`.
  - Result: `diff=0xFB`, `borrow_out=1`, `overflow=0`.
- **Signed overflow:** `a=0x80`, `b=0x01`.
  - Result: `diff=0x7F`, `borrow_out=0`, `overflow=1`.
- **Backpressure:** `out_ready` held low for 5 cycles in DONE, with a second `in_valid` pulse applied.
  - Outputs unchanged and `in_ready=0`; the second operand set is not taken.
  - After `out_ready=1`: `in_ready=1` the next cycle.
- **Reset mid-operation:** reset asserted on the 4th SHIFT cycle.
  - Next cycle: IDLE, `out_valid=0`, `diff=0`, `borrow_out=0`, `overflow=0`.
  - Follow-up `0x00 - 0x00` gives `diff=0x00`, `borrow_out=0`.
- **Exhaustive, WIDTH=4:** all 256 (a,b) pairs with random `out_ready` stalls.
  - `diff == (a-b)&0xF`.
  - `borrow_out == (a<b)`.
  - `overflow` matches the signed-range check against a reference model.
